lsu_mem_pipe: RTL and testbench

//  Consumer end of the LSU issue queue's issue handshake: accepts one issued load/store, computes the address and drives a valid/ready request to DCache.

---
 rtl/lsu_mem_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_pipe.sv
// lsu_mem_pipe
//   Consumer end of the LSU issue handshake. The block accepts one issued
//   load or store and computes its effective address. It then issues a
//   single valid/ready request to the DCache and waits for the response.
//   For a load it formats the returned word by size, sign and byte lane.
//   The result goes out on the writeback/CDB port.
//   Only one op is in flight at a time. A new op can be accepted in the same
//   cycle that the previous writeback is consumed.
//
// Build option
//   LSU_MISALIGN_CHECK_EN  When defined, a misaligned half or word access
//                          goes straight to writeback with wb_exc_o=1 and
//                          issues no DCache request. When undefined, the
//                          low address bits are forced to natural alignment
//                          and wb_exc_o is tied to 0.
//
// Ports
//   clk, rst_n (sync, active-low), flush (sync pipeline flush)
//   issue_*   : op from issue queue (valid/ready, store, size, signed,
//               base, offset, store data, ROB tag)
//   dc_req_*  : DCache request (valid/ready, word address, we, strobes,
//               lane-replicated write data)
//   dc_resp_* : DCache response (valid, read word); no backpressure
//   wb_*      : writeback (valid/ready, ROB tag, formatted data, exception)

module lsu_mem_pipe #(
   parameter int ROB_ID_W = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic                issue_store_i,
   input  logic [1:0]          issue_size_i,
   input  logic                issue_signed_i,
   input  logic [31:0]         issue_base_i,
   input  logic [31:0]         issue_offset_i,
   input  logic [31:0]         issue_wdata_i,
   input  logic [ROB_ID_W-1:0] issue_rob_id_i,
   output logic                dc_req_valid_o,
   input  logic                dc_req_ready_i,
   output logic [31:0]         dc_req_addr_o,
   output logic                dc_req_we_o,
   output logic [3:0]          dc_req_wstrb_o,
   output logic [31:0]         dc_req_wdata_o,
   input  logic                dc_resp_valid_i,
   input  logic [31:0]         dc_resp_data_i,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [ROB_ID_W-1:0] wb_rob_id_o,
   output logic [31:0]         wb_data_o,
   output logic                wb_exc_o
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_t;

   state_t state, state_nxt;

   logic                accept;
   logic signed [31:0]  addr_sum;
   logic [31:0]         addr_eff;
   logic                misalign;

   // Op registers: written only on accept or response, never reset.
   // All outputs are gated by state, so these registers are not visible
   // during reset.
   logic [31:0]         addr_q;
   logic                store_q;
   logic [1:0]          size_q;
   logic                signed_q;
   logic [ROB_ID_W-1:0] rob_q;
   logic [3:0]          wstrb_q;
   logic [31:0]         wdata_q;
   logic [31:0]         data_q;
`ifdef LSU_MISALIGN_CHECK_EN
   logic                exc_q;
`endif

   function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'd0:    return 4'b0001 << lane;
         2'd1:    return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'd0:    return {4{wdata[7:0]}};
         2'd1:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         2'd0:    return sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
         2'd1:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   // Offset is a sign-extended immediate; the sum wraps modulo 2^32.
   assign addr_sum = $signed(issue_base_i) + $signed(issue_offset_i);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign = ((issue_size_i == 2'd1) && addr_sum[0]) ||
                     (issue_size_i[1] && (addr_sum[1:0] != 2'b00));
   assign addr_eff = addr_sum;
`else
   assign misalign = 1'b0;
   assign addr_eff = (issue_size_i == 2'd0) ? addr_sum :
                     (issue_size_i == 2'd1) ? {addr_sum[31:1], 1'b0} :
                                              {addr_sum[31:2], 2'b00};
`endif

   // Flush outranks any accept. Reset also holds ready low, so no op is
   // taken while rst_n is asserted.
   assign issue_ready_o = rst_n & ~flush &
                          ((state == IDLE) | ((state == WB) & wb_ready_i));
   assign accept = issue_valid_i & issue_ready_o;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q   <= addr_eff;
         store_q  <= issue_store_i;
         size_q   <= issue_size_i;
         signed_q <= issue_signed_i;
         rob_q    <= issue_rob_id_i;
         wstrb_q  <= store_strb(issue_size_i, addr_eff[1:0]);
         wdata_q  <= store_data(issue_size_i, issue_wdata_i);
         data_q   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
         exc_q    <= misalign;
`endif
      end else if ((state == WAIT) && dc_resp_valid_i) begin
         data_q <= store_q ? 32'h0 : load_fmt(dc_resp_data_i, addr_q[1:0], size_q, signed_q);
      end
   end

   always_comb begin
      state_nxt      = state;
      dc_req_valid_o = 1'b0;
      dc_req_addr_o  = '0;
      dc_req_we_o    = 1'b0;
      dc_req_wstrb_o = '0;
      dc_req_wdata_o = '0;
      wb_valid_o     = 1'b0;
      wb_rob_id_o    = '0;
      wb_data_o      = '0;
      wb_exc_o       = 1'b0;

      case (state)
         IDLE: begin
            if (accept) state_nxt = misalign ? WB : REQ;
         end
         REQ: begin
            dc_req_valid_o = 1'b1;
            dc_req_addr_o  = {addr_q[31:2], 2'b00};
            dc_req_we_o    = store_q;
            dc_req_wstrb_o = store_q ? wstrb_q : 4'b0000;
            dc_req_wdata_o = store_q ? wdata_q : 32'h0;
            // If the request was handed off in the flush cycle, a response
            // is still owed and must be drained.
            if (flush)               state_nxt = dc_req_ready_i ? DRAIN : IDLE;
            else if (dc_req_ready_i) state_nxt = WAIT;
         end
         WAIT: begin
            // A response arriving together with flush is consumed here, so
            // nothing is left to drain.
            if (dc_resp_valid_i) state_nxt = flush ? IDLE : WB;
            else if (flush)      state_nxt = DRAIN;
         end
         WB: begin
            wb_valid_o  = 1'b1;
            wb_rob_id_o = rob_q;
            wb_data_o   = data_q;
`ifdef LSU_MISALIGN_CHECK_EN
            wb_exc_o    = exc_q;
`endif
            if (flush)           state_nxt = IDLE;
            else if (wb_ready_i) state_nxt = accept ? (misalign ? WB : REQ) : IDLE;
         end
         DRAIN: begin
            if (dc_resp_valid_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_pipe.sv
// tb_lsu_mem_pipe
//   Directed bench for lsu_mem_pipe. A table of single-op vectors runs
//   against a zero-wait DCache. Hand-written sequences follow for flush,
//   writeback backpressure and misaligned access.

module tb_lsu_mem_pipe;

   localparam int ROB_W = 6;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             issue_valid_i;
   logic             issue_ready_o;
   logic             issue_store_i;
   logic [1:0]       issue_size_i;
   logic             issue_signed_i;
   logic [31:0]      issue_base_i;
   logic [31:0]      issue_offset_i;
   logic [31:0]      issue_wdata_i;
   logic [ROB_W-1:0] issue_rob_id_i;
   logic             dc_req_valid_o;
   logic             dc_req_ready_i;
   logic [31:0]      dc_req_addr_o;
   logic             dc_req_we_o;
   logic [3:0]       dc_req_wstrb_o;
   logic [31:0]      dc_req_wdata_o;
   logic             dc_resp_valid_i;
   logic [31:0]      dc_resp_data_i;
   logic             wb_valid_o;
   logic             wb_ready_i;
   logic [ROB_W-1:0] wb_rob_id_o;
   logic [31:0]      wb_data_o;
   logic             wb_exc_o;

   int errors = 0;
   int checks = 0;

   lsu_mem_pipe #(.ROB_ID_W(ROB_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_store_i(issue_store_i), .issue_size_i(issue_size_i),
      .issue_signed_i(issue_signed_i), .issue_base_i(issue_base_i),
      .issue_offset_i(issue_offset_i), .issue_wdata_i(issue_wdata_i),
      .issue_rob_id_i(issue_rob_id_i),
      .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
      .dc_req_addr_o(dc_req_addr_o), .dc_req_we_o(dc_req_we_o),
      .dc_req_wstrb_o(dc_req_wstrb_o), .dc_req_wdata_o(dc_req_wdata_o),
      .dc_resp_valid_i(dc_resp_valid_i), .dc_resp_data_i(dc_resp_data_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_rob_id_o(wb_rob_id_o), .wb_data_o(wb_data_o), .wb_exc_o(wb_exc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        store;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] base;
      logic [31:0] offset;
      logic [31:0] wdata;
      logic [31:0] resp;
      logic [31:0] exp_addr;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_wb;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] b, input logic [31:0] o,
                           input logic [31:0] wd, input logic [ROB_W-1:0] rob);
      issue_valid_i  = 1'b1;
      issue_store_i  = st;
      issue_size_i   = sz;
      issue_signed_i = sg;
      issue_base_i   = b;
      issue_offset_i = o;
      issue_wdata_i  = wd;
      issue_rob_id_i = rob;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      drive_op(v.store, v.size, v.sgn, v.base, v.offset, v.wdata, ROB_W'(idx + 1));
      #1;
      check($sformatf("v%0d issue_ready", idx), 32'(issue_ready_o), 32'd1);
      step();                                   // accept edge
      issue_valid_i = 1'b0;
      #1;
      check($sformatf("v%0d req_valid", idx), 32'(dc_req_valid_o), 32'd1);
      check($sformatf("v%0d req_addr", idx), dc_req_addr_o, v.exp_addr);
      check($sformatf("v%0d req_we", idx), 32'(dc_req_we_o), 32'(v.store));
      check($sformatf("v%0d req_wstrb", idx), 32'(dc_req_wstrb_o), 32'(v.exp_strb));
      check($sformatf("v%0d req_wdata", idx), dc_req_wdata_o, v.exp_wdata);
      check($sformatf("v%0d wb_early", idx), 32'(wb_valid_o), 32'd0);
      step();                                   // request handed off, now WAIT
      dc_resp_valid_i = 1'b1;
      dc_resp_data_i  = v.resp;
      #1;
      check($sformatf("v%0d req_dropped", idx), 32'(dc_req_valid_o), 32'd0);
      check($sformatf("v%0d wb_not_yet", idx), 32'(wb_valid_o), 32'd0);
      step();                                   // WB
      dc_resp_valid_i = 1'b0;
      #1;
      check($sformatf("v%0d wb_valid", idx), 32'(wb_valid_o), 32'd1);
      check($sformatf("v%0d wb_data", idx), wb_data_o, v.exp_wb);
      check($sformatf("v%0d wb_rob", idx), 32'(wb_rob_id_o), 32'(idx + 1));
      check($sformatf("v%0d wb_exc", idx), 32'(wb_exc_o), 32'd0);
      step();                                   // consumed, back to IDLE
      check($sformatf("v%0d wb_done", idx), 32'(wb_valid_o), 32'd0);
   endtask

   initial begin
      // store size sgn base offset wdata resp | addr strb wdata wb
      vecs[0] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h0,        32'h8899AABB, 32'h1000, 4'b0000, 32'h0,        32'h8899AABB};
      vecs[1] = '{1'b0, 2'd0, 1'b1, 32'h1000, 32'h3,        32'h0,        32'h80112233, 32'h1000, 4'b0000, 32'h0,        32'hFFFFFF80};
      vecs[2] = '{1'b0, 2'd0, 1'b0, 32'h1000, 32'h3,        32'h0,        32'h80112233, 32'h1000, 4'b0000, 32'h0,        32'h00000080};
      vecs[3] = '{1'b1, 2'd1, 1'b0, 32'h1000, 32'h2,        32'h0000BEEF, 32'h12345678, 32'h1000, 4'b1100, 32'hBEEFBEEF, 32'h0};
      vecs[4] = '{1'b0, 2'd1, 1'b1, 32'h2000, 32'hFFFFFFFE, 32'h0,        32'hABCD1234, 32'h1FFC, 4'b0000, 32'h0,        32'hFFFFABCD};
      vecs[5] = '{1'b0, 2'd1, 1'b0, 32'h3000, 32'h4,        32'h0,        32'h0000F00D, 32'h3004, 4'b0000, 32'h0,        32'h0000F00D};
      vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h10,   32'h1,        32'h123456A5, 32'h0,        32'h10,   4'b0010, 32'hA5A5A5A5, 32'h0};
      vecs[7] = '{1'b1, 2'd3, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 32'h0,        32'h40,   4'b1111, 32'hDEADBEEF, 32'h0};
      vecs[8] = '{1'b0, 2'd0, 1'b0, 32'h100,  32'h2,        32'h0,        32'h00FE0000, 32'h100,  4'b0000, 32'h0,        32'h000000FE};

      rst_n = 1'b0; flush = 1'b0;
      issue_valid_i = 1'b0; issue_store_i = 1'b0; issue_size_i = 2'd0; issue_signed_i = 1'b0;
      issue_base_i = '0; issue_offset_i = '0; issue_wdata_i = '0; issue_rob_id_i = '0;
      dc_req_ready_i = 1'b1; dc_resp_valid_i = 1'b0; dc_resp_data_i = '0; wb_ready_i = 1'b1;

      // Reset: every output low, including issue_ready.
      step(); step();
      check("rst issue_ready", 32'(issue_ready_o), 32'd0);
      check("rst req_valid", 32'(dc_req_valid_o), 32'd0);
      check("rst req_addr", dc_req_addr_o, 32'h0);
      check("rst wb_valid", 32'(wb_valid_o), 32'd0);
      check("rst wb_data", wb_data_o, 32'h0);
      rst_n = 1'b1;
      step();
      check("post-rst issue_ready", 32'(issue_ready_o), 32'd1);

      for (int i = 0; i < 9; i++) run_vec(i);

      // LW at 0x1001: exception path with the check, forced alignment without.
      drive_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h1, 32'h0, 6'd20);
      step();
      issue_valid_i = 1'b0;
      #1;
`ifdef LSU_MISALIGN_CHECK_EN
      check("mis req_valid", 32'(dc_req_valid_o), 32'd0);
      check("mis wb_valid", 32'(wb_valid_o), 32'd1);
      check("mis wb_exc", 32'(wb_exc_o), 32'd1);
      check("mis wb_data", wb_data_o, 32'h0);
      step();
      check("mis wb_done", 32'(wb_valid_o), 32'd0);
`else
      check("mis req_valid", 32'(dc_req_valid_o), 32'd1);
      check("mis req_addr", dc_req_addr_o, 32'h1000);
      step();
      dc_resp_valid_i = 1'b1; dc_resp_data_i = 32'hCAFEF00D;
      step();
      dc_resp_valid_i = 1'b0;
      #1;
      check("mis wb_valid", 32'(wb_valid_o), 32'd1);
      check("mis wb_exc", 32'(wb_exc_o), 32'd0);
      check("mis wb_data", wb_data_o, 32'hCAFEF00D);
      step();
`endif

      // Flush in WAIT, response two cycles later, flush repeated in DRAIN.
      drive_op(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0, 6'd30);
      step();
      issue_valid_i = 1'b0;
      step();                                   // WAIT
      flush = 1'b1;
      #1;
      check("fw ready_in_flush", 32'(issue_ready_o), 32'd0);
      step();                                   // DRAIN
      drive_op(1'b0, 2'd2, 1'b0, 32'h700, 32'h0, 32'h0, 6'd31);
      #1;
      check("fw drain_ready", 32'(issue_ready_o), 32'd0);
      step();                                   // flush in DRAIN: still DRAIN
      flush = 1'b0;
      #1;
      check("fw drain_hold_ready", 32'(issue_ready_o), 32'd0);
      check("fw drain_no_req", 32'(dc_req_valid_o), 32'd0);
      dc_resp_valid_i = 1'b1; dc_resp_data_i = 32'h55555555;
      #1;
      check("fw resp_cycle_ready", 32'(issue_ready_o), 32'd0);
      check("fw resp_cycle_wb", 32'(wb_valid_o), 32'd0);
      step();                                   // IDLE
      dc_resp_valid_i = 1'b0; issue_valid_i = 1'b0;
      #1;
      check("fw idle_ready", 32'(issue_ready_o), 32'd1);
      check("fw no_wb", 32'(wb_valid_o), 32'd0);
      check("fw no_req", 32'(dc_req_valid_o), 32'd0);

      // Writeback held off for 3 cycles with the next op waiting.
      wb_ready_i = 1'b0;
      drive_op(1'b0, 2'd0, 1'b0, 32'h1000, 32'h1, 32'h0, 6'd5);
      step();
      issue_valid_i = 1'b0;
      step();
      dc_resp_valid_i = 1'b1; dc_resp_data_i = 32'h0000AB00;
      step();                                   // WB
      dc_resp_valid_i = 1'b0;
      drive_op(1'b0, 2'd2, 1'b0, 32'h2000, 32'h8, 32'h0, 6'd7);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp%0d wb_valid", k), 32'(wb_valid_o), 32'd1);
         check($sformatf("bp%0d wb_data", k), wb_data_o, 32'h000000AB);
         check($sformatf("bp%0d wb_rob", k), 32'(wb_rob_id_o), 32'd5);
         check($sformatf("bp%0d issue_ready", k), 32'(issue_ready_o), 32'd0);
         step();
      end
      wb_ready_i = 1'b1;
      #1;
      check("bp release_ready", 32'(issue_ready_o), 32'd1);
      check("bp release_wb", 32'(wb_valid_o), 32'd1);
      step();                                   // new op accepted -> REQ
      issue_valid_i = 1'b0;
      #1;
      check("bp next_req", 32'(dc_req_valid_o), 32'd1);
      check("bp next_addr", dc_req_addr_o, 32'h2008);
      check("bp next_wb_low", 32'(wb_valid_o), 32'd0);
      step();
      dc_resp_valid_i = 1'b1; dc_resp_data_i = 32'h11223344;
      step();
      dc_resp_valid_i = 1'b0;
      #1;
      check("bp next_wb_data", wb_data_o, 32'h11223344);
      check("bp next_wb_rob", 32'(wb_rob_id_o), 32'd7);
      step();

      // Flush in REQ while DCache stalls: request dropped, no drain needed.
      dc_req_ready_i = 1'b0;
      drive_op(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 32'h0, 6'd9);
      step();
      issue_valid_i = 1'b0;
      step();
      check("fr stalled_req", 32'(dc_req_valid_o), 32'd1);
      check("fr stalled_addr", dc_req_addr_o, 32'h600);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check("fr req_gone", 32'(dc_req_valid_o), 32'd0);
      check("fr idle_ready", 32'(issue_ready_o), 32'd1);
      dc_req_ready_i = 1'b1;

      // Flush in REQ in the same cycle the request is taken: drain the response.
      drive_op(1'b0, 2'd2, 1'b0, 32'h640, 32'h0, 32'h0, 6'd10);
      step();
      issue_valid_i = 1'b0;
      flush = 1'b1;
      step();                                   // DRAIN
      flush = 1'b0;
      #1;
      check("frr drain_ready", 32'(issue_ready_o), 32'd0);
      dc_resp_valid_i = 1'b1; dc_resp_data_i = 32'h77777777;
      step();
      dc_resp_valid_i = 1'b0;
      #1;
      check("frr idle_ready", 32'(issue_ready_o), 32'd1);
      check("frr no_wb", 32'(wb_valid_o), 32'd0);

      // Flush in WB beats both writeback and a pending accept.
      wb_ready_i = 1'b0;
      drive_op(1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 32'h0, 6'd11);
      step();
      issue_valid_i = 1'b0;
      step();
      dc_resp_valid_i = 1'b1; dc_resp_data_i = 32'h01020304;
      step();                                   // WB
      dc_resp_valid_i = 1'b0;
      wb_ready_i = 1'b1;
      flush = 1'b1;
      drive_op(1'b0, 2'd2, 1'b0, 32'h900, 32'h0, 32'h0, 6'd12);
      #1;
      check("fwb ready_blocked", 32'(issue_ready_o), 32'd0);
      step();
      flush = 1'b0; issue_valid_i = 1'b0;
      #1;
      check("fwb wb_gone", 32'(wb_valid_o), 32'd0);
      check("fwb no_req", 32'(dc_req_valid_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
